stopwatch_core: RTL and testbench

- Synthesizable stopwatch that consumes the bench-driven clock, reset, button and switch stimulus.
- Conditions the raw button (synchroniser, debounce, press detect) and runs a start/stop/clear FSM.
- Produces BCD seconds digits plus one-cycle second and minute pulses for the display and monitor logic.

---
 rtl/stopwatch_core_if.sv | 32 +++
 rtl/stopwatch_core.sv | 245 ++++++++++++++++++++++++
 tb/tb_stopwatch_core.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// stopwatch_core_if: bundles the stopwatch user controls and display/monitor outputs.
// The master side drives the button and switch and observes the outputs. The slave
// side is the stopwatch core itself.
interface stopwatch_core_if;
  logic       button;        // raw asynchronous push button, active-high
  logic       switch;        // mode select: 0 = start/stop, 1 = clear (lap with macro)
  logic [3:0] low_sec_dig;   // seconds units, BCD 0-9
  logic [2:0] high_sec_dig;  // seconds tens, BCD 0-5
  logic       second;        // one-cycle pulse on every seconds increment
  logic       minute;        // one-cycle pulse on the 59 -> 00 wrap
  logic       running;       // high while the watch is running

  modport master (
    output button,
    output switch,
    input  low_sec_dig,
    input  high_sec_dig,
    input  second,
    input  minute,
    input  running
  );

  modport slave (
    input  button,
    input  switch,
    output low_sec_dig,
    output high_sec_dig,
    output second,
    output minute,
    output running
  );
endinterface

// File: rtl/stopwatch_core.sv
// stopwatch_core: seconds stopwatch with a conditioned push button.
//   - button: 2-flop synchroniser, level debouncer, rising-edge press detect
//   - switch: 2-flop synchroniser only
//   - STOPPED/RUNNING FSM; a press with switch=0 toggles start/stop, a press with
//     switch=1 while stopped clears the count
//   - prescaler divides clock by TICKS_PER_SEC into BCD seconds 00..59 with
//     registered second/minute pulses
// Optional build macro STOPWATCH_LAP_HOLD_EN: a press with switch=1 while running
// toggles a lap hold that freezes the displayed digits while counting continues.
module stopwatch_core #(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  stopwatch_core_if.slave  sw_if
);

  localparam int PW = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchronisers: bit 0 = button, bit 1 = switch
  // ---------------------------------------------------------------------------
  logic [1:0] w_raw;
  logic [1:0] w_sync;

  assign w_raw = {sw_if.switch, sw_if.button};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      logic r_meta;
      logic r_sync;

      // two-flop synchroniser for one asynchronous input
      always_ff @(posedge clock) begin
        if (reset) begin
          r_meta <= 1'b0;
          r_sync <= 1'b0;
        end else begin
          r_meta <= w_raw[gi];
          r_sync <= r_meta;
        end
      end

      assign w_sync[gi] = r_sync;
    end
  endgenerate

  logic w_btn_sync;
  logic w_sw_sync;

  assign w_btn_sync = w_sync[0];
  assign w_sw_sync  = w_sync[1];

  // ---------------------------------------------------------------------------
  // Debouncer and press detect
  // ---------------------------------------------------------------------------
  logic          r_deb_level;
  logic [DW-1:0] r_deb_cnt;
  logic          w_btn_differs;
  logic          w_deb_accept;
  logic          w_press;

  assign w_btn_differs = (w_btn_sync != r_deb_level);
  // The Nth consecutive differing sample is the one that flips the level.
  assign w_deb_accept  = w_btn_differs && (r_deb_cnt == DEB_LAST);
  // The press is raised in the same cycle the new level is accepted. That way the
  // FSM acts on the edge where the debounced level changes, with no extra delay.
  assign w_press       = w_deb_accept && w_btn_sync;

  // count consecutive differing samples and accept the new level after enough of them
  always_ff @(posedge clock) begin
    if (reset) begin
      r_deb_level <= 1'b0;
      r_deb_cnt   <= '0;
    end else if (!w_btn_differs) begin
      r_deb_cnt   <= '0;
    end else if (w_deb_accept) begin
      r_deb_level <= w_btn_sync;
      r_deb_cnt   <= '0;
    end else begin
      r_deb_cnt   <= r_deb_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Start/stop/clear FSM
  // ---------------------------------------------------------------------------
  state_t r_state;
  state_t w_state_next;
  logic   w_clear;
  logic   w_stop_edge;
`ifdef STOPWATCH_LAP_HOLD_EN
  logic   w_lap_toggle;
`endif

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_STOPPED;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state decode and single-cycle command strobes
  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    w_lap_toggle = 1'b0;
`endif
    case (r_state)
      ST_STOPPED: begin
        if (w_press) begin
          if (!w_sw_sync) begin
            w_state_next = ST_RUNNING;
          end else begin
            w_clear = 1'b1;
          end
        end
      end
      ST_RUNNING: begin
        if (w_press) begin
          if (!w_sw_sync) begin
            w_state_next = ST_STOPPED;
          end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
            w_lap_toggle = 1'b1;
`endif
          end
        end
      end
      default: begin
        w_state_next = ST_STOPPED;
      end
    endcase
  end

  assign w_stop_edge = (r_state == ST_RUNNING) && (w_state_next == ST_STOPPED);

  // ---------------------------------------------------------------------------
  // Prescaler and BCD seconds counter
  // ---------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic [3:0]    r_low;
  logic [2:0]    r_high;
  logic          r_second;
  logic          r_minute;
  logic          w_count_en;
  logic          w_tc;
  logic          w_units_last;
  logic          w_tens_last;

  // A stop press in the same cycle as a terminal count still lets that increment
  // happen, because counting depends only on the current state.
  assign w_count_en   = (r_state == ST_RUNNING);
  assign w_tc         = w_count_en && (r_presc == PRESC_LAST);
  assign w_units_last = (r_low == 4'd9);
  assign w_tens_last  = (r_high == 3'd5);

  // divide the clock into seconds and advance the BCD digits
  always_ff @(posedge clock) begin
    if (reset) begin
      r_presc  <= '0;
      r_low    <= 4'd0;
      r_high   <= 3'd0;
      r_second <= 1'b0;
      r_minute <= 1'b0;
    end else begin
      r_second <= w_tc;
      r_minute <= w_tc && w_units_last && w_tens_last;
      if (w_clear) begin
        r_presc <= '0;
        r_low   <= 4'd0;
        r_high  <= 3'd0;
      end else if (w_count_en) begin
        if (w_tc) begin
          r_presc <= '0;
          if (w_units_last) begin
            r_low <= 4'd0;
            if (w_tens_last) begin
              r_high <= 3'd0;
            end else begin
              r_high <= r_high + 3'd1;
            end
          end else begin
            r_low <= r_low + 4'd1;
          end
        end else begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Display path (optional lap hold)
  // ---------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_HOLD_EN
  logic       r_lap;
  logic [3:0] r_lap_low;
  logic [2:0] r_lap_high;

  // toggle the lap hold and snapshot the digits showing when the hold begins
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lap      <= 1'b0;
      r_lap_low  <= 4'd0;
      r_lap_high <= 3'd0;
    end else if (w_stop_edge) begin
      r_lap <= 1'b0;
    end else if (w_lap_toggle) begin
      r_lap <= !r_lap;
      if (!r_lap) begin
        r_lap_low  <= r_low;
        r_lap_high <= r_high;
      end
    end
  end

  assign sw_if.low_sec_dig  = r_lap ? r_lap_low  : r_low;
  assign sw_if.high_sec_dig = r_lap ? r_lap_high : r_high;
`else
  logic w_unused;

  // The stop edge only matters for releasing the lap hold.
  assign w_unused           = w_stop_edge;
  assign sw_if.low_sec_dig  = r_low;
  assign sw_if.high_sec_dig = r_high;
`endif

  assign sw_if.second  = r_second;
  assign sw_if.minute  = r_minute;
  assign sw_if.running = (r_state == ST_RUNNING);

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: randomized button/switch stimulus against a tick-counting
// reference model. Expected second/minute pulses are queued by the model. A
// negedge monitor pops them whenever the DUT pulses and also compares the
// running flag and the displayed digits every cycle.
// Define STOPWATCH_LAP_HOLD_EN for both DUT and bench to cover the lap hold.
module tb_stopwatch_core;
  localparam int T = 4;
  localparam int D = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #1 clock = ~clock;

  stopwatch_core_if sw_if ();

  stopwatch_core #(
    .TICKS_PER_SEC   (T),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clock (clock),
    .reset (reset),
    .sw_if (sw_if)
  );

  typedef struct {
    int secs;
    bit minute;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t p;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state: elapsed ticks since the last clear, modulo one minute
  int m_ticks = 0;
  bit m_run = 1'b0;
  bit m_lap = 1'b0;
  int m_lap_secs = 0;
  int press_at = -1;
  bit press_sw = 1'b0;
  int secs_before;
  int disp;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // reference model: advance one clock edge
  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_run    = 1'b0;
      m_ticks  = 0;
      m_lap    = 1'b0;
      press_at = -1;
    end else begin
      secs_before = m_ticks / T;
      if (m_run) begin
        m_ticks = (m_ticks + 1) % (60 * T);
        if (m_ticks % T == 0) exp_q.push_back(pulse_t'{m_ticks / T, m_ticks == 0});
      end
      if (press_at == cyc) begin
        press_at = -1;
        if (!press_sw) begin
          if (m_run) m_lap = 1'b0;
          m_run = !m_run;
        end else if (!m_run) begin
          m_ticks = 0;
        end else begin
`ifdef STOPWATCH_LAP_HOLD_EN
          if (!m_lap) m_lap_secs = secs_before;
          m_lap = !m_lap;
`endif
        end
      end
    end
  end

  // monitor: compare DUT outputs with the model away from the active edge
  always @(negedge clock) begin
    disp = m_lap ? m_lap_secs : (m_ticks / T);
    chk("running", int'(sw_if.running), int'(m_run));
    chk("low_sec_dig", int'(sw_if.low_sec_dig), disp % 10);
    chk("high_sec_dig", int'(sw_if.high_sec_dig), disp / 10);
    if (sw_if.second || exp_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_second", int'(sw_if.second), 0);
      end else begin
        p = exp_q.pop_front();
        chk("second_pulse", int'(sw_if.second), 1);
        chk("minute_pulse", int'(sw_if.minute), int'(p.minute));
        if (!m_lap) chk("pulse_secs", int'(sw_if.high_sec_dig) * 10 + int'(sw_if.low_sec_dig), p.secs);
      end
    end else begin
      chk("minute_idle", int'(sw_if.minute), 0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // raw button pulse of len cycles with the given switch setting
  task automatic button_pulse(input bit sw, input int len);
    @(negedge clock);
    sw_if.switch = sw;
    idle(3);
    sw_if.button = 1'b1;
    if (len >= D) begin
      press_at = cyc + 2 + D;
      press_sw = sw;
    end
    $display("txn cycle %0d: button len=%0d switch=%0d press=%0d running=%0d secs=%0d",
             cyc, len, sw, (len >= D), m_run, m_ticks / T);
    idle(len);
    sw_if.button = 1'b0;
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    $display("txn cycle %0d: reset for %0d cycles at secs=%0d", cyc, n, m_ticks / T);
    idle(n);
    reset = 1'b0;
  endtask

  initial begin
    int r;
    sw_if.button = 1'b0;
    sw_if.switch = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(100);

    button_pulse(1'b0, 2);       // glitch: no press
    idle(20);
    button_pulse(1'b0, 10);      // start
    idle(250);                   // passes the 59 -> 00 wrap
    button_pulse(1'b0, 10);      // stop
    idle(20);
    button_pulse(1'b1, 10);      // clear while stopped
    idle(20);
    button_pulse(1'b0, D);       // shortest accepted press: start
    idle(40);
    button_pulse(1'b1, 10);      // switch=1 while running
    idle(30);
    button_pulse(1'b0, 10);      // stop
    idle(15);
    button_pulse(1'b0, 10);      // resume partial second
    idle(30);

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        pulse_reset(int'($urandom_range(1, 3)));
      end else if (r == 3) begin
        button_pulse(1'($urandom_range(0, 1)), int'($urandom_range(1, D - 1)));
      end else begin
        button_pulse(r <= 2, int'($urandom_range(D, 12)));
      end
      idle(int'($urandom_range(12, 70)));
    end

    idle(20);
    chk("pending_pulses", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL timeout cycle %0d: got running bench expected finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
